regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load/multi-cycle unit).
- Each requester is buffered in its own small FIFO.
- A round-robin arbiter drains the FIFOs into a registered write port.
- A hazard query port reports whether a write to a given register is still in flight.

---
 rtl/regfile_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for the register file's single write port.
// Each requester has its own FIFO; a round-robin grant drains them into a registered write port.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DROP_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_data,

    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic              idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_addr   [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [ADDR_W-1:0] head_addr [2];
    logic [DATA_W-1:0] head_data [2];
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        nonempty;
    logic [1:0]        buf_hit;
    logic [1:0]        gnt;

    logic              rr_ptr_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_wr_q;
    logic [DATA_W-1:0] rf_data_q;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [ADDR_W-1:0] mem_addr [DEPTH];
        logic [DATA_W-1:0] mem_data [DEPTH];
        logic [PW-1:0]     wptr_q;
        logic [PW-1:0]     rptr_q;
        logic [CW-1:0]     count_q;
        logic              hit;

        // Ready comes from the registered count only: a full FIFO never accepts, even when popping.
        assign ready[g]     = rst_n && (count_q != FULL);
        assign push[g]      = in_valid[g] && ready[g];
        assign nonempty[g]  = (count_q != '0);
        assign head_addr[g] = mem_addr[rptr_q];
        assign head_data[g] = mem_data[rptr_q];
        assign buf_hit[g]   = hit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push[g]) begin
                    wptr_q <= wptr_q + 1'b1;
                end
                if (gnt[g]) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                if (push[g] && !gnt[g]) begin
                    count_q <= count_q + 1'b1;
                end else if (!push[g] && gnt[g]) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_addr[wptr_q] <= in_addr[g];
                mem_data[wptr_q] <= in_data[g];
            end
        end

        // Only the count_q slots starting at the read pointer hold live entries.
        always_comb begin
            hit = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if ((CW'(k) < count_q) && (mem_addr[rptr_q + PW'(k)] == q_addr)) begin
                    hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt = nonempty;
        if (nonempty == 2'b11) begin
            gnt = rr_ptr_q ? 2'b10 : 2'b01;
        end
    end

    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_drop;

    assign sel      = gnt[1];
    assign sel_addr = head_addr[sel];
    assign sel_data = head_data[sel];
    assign sel_drop = (DROP_R0 != 0) && (sel_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_wr_q   <= '0;
            rf_data_q <= '0;
        end else if (gnt != 2'b00) begin
            // Priority passes to the requester that was not granted; dropped entries count too.
            rr_ptr_q  <= gnt[0];
            rf_we_q   <= !sel_drop;
            rf_wr_q   <= sel_addr;
            rf_data_q <= sel_data;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign rf_we      = rf_we_q;
    assign rf_wr      = rf_wr_q;
    assign rf_data    = rf_data_q;
    assign q_hit      = (q_addr != '0) && ((buf_hit != 2'b00) || (rf_we_q && (rf_wr_q == q_addr)));
    assign idle       = (nonempty == 2'b00) && !rf_we_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DROP  = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, rf_wr, q_addr;
    logic [DW-1:0] req0_data, req1_data, rf_data;
    logic          rf_we, q_hit, idle;

    regfile_write_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .DROP_R0(DROP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .rf_we     (rf_we),
        .rf_wr     (rf_wr),
        .rf_data   (rf_data),
        .q_addr    (q_addr),
        .q_hit     (q_hit),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    // Reference model: one queue per requester, a round-robin bit, and the last issue state.
    ent_t          mq [2][$];
    exp_t          sb [$];
    int            rr;
    bit            m_we;
    logic [AW-1:0] m_wr;
    int            cyc;
    int            checks;
    int            errors;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [AW-1:0] qa);
        if (qa == 0) return 1'b0;
        if (m_we && m_wr == qa) return 1'b1;
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < mq[g].size(); k++) begin
                if (mq[g][k].addr == qa) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Monitor: every issued write must be the oldest outstanding expectation, in the right cycle.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write at cycle %0d: got addr %0d data 0x%0h, none expected",
                         cyc, rf_wr, rf_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(rf_wr), 64'(e.addr));
                check("wr_data", 64'(rf_data), 64'(e.data));
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic do_cycle(input bit v0, input bit v1, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1, input logic [AW-1:0] qa);
        int   s [2];
        int   g;
        ent_t e;
        bit   v [2];
        ent_t n [2];
        @(negedge clk);
        q_addr = qa;
        #1;
        check("req0_ready", 64'(req0_ready), 64'(mq[0].size() != DEPTH));
        check("req1_ready", 64'(req1_ready), 64'(mq[1].size() != DEPTH));
        check("idle", 64'(idle), 64'(mq[0].size() == 0 && mq[1].size() == 0 && !m_we));
        check("q_hit", 64'(q_hit), 64'(model_hit(qa)));

        v[0] = v0;
        v[1] = v1;
        n[0] = '{a0, $urandom};
        n[1] = '{a1, $urandom};
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = n[0].data;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = n[1].data;

        s[0] = mq[0].size();
        s[1] = mq[1].size();
        g = -1;
        if (s[0] != 0 && s[1] != 0) g = rr;
        else if (s[0] != 0) g = 0;
        else if (s[1] != 0) g = 1;
        m_we = 1'b0;
        if (g >= 0) begin
            e = mq[g].pop_front();
            rr = (g == 0) ? 1 : 0;
            if (!(DROP != 0 && e.addr == 0)) begin
                sb.push_back('{e.addr, e.data, cyc + 1});
                m_we = 1'b1;
                m_wr = e.addr;
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (v[r] && s[r] != DEPTH) mq[r].push_back(n[r]);
        end
    endtask

    task automatic rand_cycle(input int p0, input int p1, input int amax);
        do_cycle($urandom_range(0, 99) < p0, $urandom_range(0, 99) < p1,
                 AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)),
                 AW'($urandom_range(0, amax)));
    endtask

    task automatic mid_reset();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);
        mq[0].delete();
        mq[1].delete();
        sb.delete();
        rr   = 0;
        m_we = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rr     = 0;
        m_we   = 1'b0;
        m_wr   = '0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
        q_addr     = '0;
        #2;
        check("reset_we", 64'(rf_we), 64'd0);
        check("reset_wr", 64'(rf_wr), 64'd0);
        check("reset_data", 64'(rf_data), 64'd0);
        check("reset_ready0", 64'(req0_ready), 64'd0);
        check("reset_ready1", 64'(req1_ready), 64'd0);
        check("reset_idle", 64'(idle), 64'd1);
        #1;
        rst_n = 1'b1;

        // Single write, then quiet so idle returns.
        do_cycle(1'b1, 1'b0, AW'(5), AW'(0), AW'(5));
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, '0, '0, AW'(5));

        // Both requesters stream four writes from the same edge.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b1, AW'(1 + i), AW'(11 + i), AW'(12));
        end
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b0, '0, '0, AW'(13));

        // Address-0 write is swallowed; queried address 0 never hits.
        do_cycle(1'b1, 1'b0, AW'(0), AW'(0), AW'(0));
        do_cycle(1'b1, 1'b0, AW'(3), AW'(0), AW'(0));
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, '0, '0, AW'(0));

        // Hazard window on requester 1.
        do_cycle(1'b0, 1'b1, AW'(0), AW'(7), AW'(7));
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, '0, '0, AW'(7));

        // Backpressure and mixed traffic with small address space for collisions and drops.
        for (int i = 0; i < 60; i++) rand_cycle(100, 100, 7);
        for (int i = 0; i < 150; i++) rand_cycle(60, 40, 7);
        for (int i = 0; i < 100; i++) rand_cycle(30, 80, 31);

        // Reset with both FIFOs full.
        for (int i = 0; i < 6; i++) rand_cycle(100, 100, 7);
        mid_reset();
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, '0, '0, AW'($urandom_range(0, 7)));
        for (int i = 0; i < 80; i++) rand_cycle(50, 50, 7);

        for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, '0, '0, AW'($urandom_range(0, 7)));
        check("drain_outstanding", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
